muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the RS/RT read-port data for MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers.
- The hazard unit stalls on busy_o. MFHI/MFLO read HI_o/LO_o directly.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] RSdata_i,
  input  logic [WIDTH-1:0] RTdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] HI_o,
  output logic [WIDTH-1:0] LO_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     rs_mag, rt_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_shift, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    signed_op = op_i[0];
    rs_mag    = (signed_op && RSdata_i[WIDTH-1]) ? -RSdata_i : RSdata_i;
    rt_mag    = (signed_op && RTdata_i[WIDTH-1]) ? -RTdata_i : RTdata_i;

    // acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // acc = {partial remainder, dividend bits shifting into quotient bits}
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = rem_shift - {1'b0, opb_q};
    div_next  = div_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_fix = neg_quo_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = op_i[1] ? StDiv : StMul;
          cnt_d     = '0;
          div_d     = op_i[1];
          neg_quo_d = signed_op & (RSdata_i[WIDTH-1] ^ RTdata_i[WIDTH-1]);
          neg_rem_d = signed_op & RSdata_i[WIDTH-1];
          opb_d     = rt_mag;
          acc_d     = {{WIDTH{1'b0}}, rs_mag};
        end else begin
          state_d = StIdle;
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = StFix;
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        state_d = StDone;
        if (!div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (opb_q == '0) begin
          // With a zero divisor the remainder is |RS|; re-applying RS's sign restores RS.
          hi_d = neg_rem_q ? -rem : rem;
          lo_d = '1;
        end else begin
          hi_d = neg_rem_q ? -rem : rem;
          lo_d = neg_quo_q ? -quo : quo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
  assign done_o = (state_q == StDone);
  assign HI_o   = hi_q;
  assign LO_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, random ops against an
// arithmetic reference model, back-to-back issue and asynchronous reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .start_i  (start),
    .op_i     (op),
    .RSdata_i (rs),
    .RTdata_i (rt),
    .busy_o   (busy),
    .done_o   (done),
    .HI_o     (hi),
    .LO_o     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mop)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: p = 64'(sa * sb);
      default: begin
        if (b == 32'b0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (mop == 2'b10) begin
          p = {a % b, a / b};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Inputs are don't-care once accepted.
    op    = 2'($urandom_range(0, 3));
    rs    = $urandom;
    rt    = $urandom;
  endtask

  // Counts busy cycles (sampled on negedges) and checks HI/LO stay put meanwhile.
  task automatic wait_result(output int nbusy, output bit held, output bit done_seen);
    logic [31:0] ph, pl;
    ph = hi;
    pl = lo;
    nbusy = 0;
    held = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        done_seen = done;
        break;
      end
      nbusy++;
      if (hi !== ph || lo !== pl) held = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    rs    = 32'b0;
    rt    = 32'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (hi !== 32'b0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
    n_total++; if (lo !== 32'b0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
  } vec_t;

  task automatic test_directed;
    vec_t v[8];
    int   nb;
    bit   held, ds;
    v[0] = '{2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    v[1] = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    v[2] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA};
    v[3] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[4] = '{2'b10, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    v[5] = '{2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    v[6] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    v[7] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    for (int i = 0; i < 8; i++) begin
      issue(v[i].o, v[i].a, v[i].b);
      wait_result(nb, held, ds);
      n_total++;
      if (nb != 33) $display("FAIL dir%0d_busy_cycles got %0d want 33", i, nb); else n_pass++;
      n_total++;
      if (!held) $display("FAIL dir%0d_hilo_hold got changed want held", i); else n_pass++;
      n_total++;
      if (ds !== 1'b1) $display("FAIL dir%0d_done got %b want 1", i, ds); else n_pass++;
      n_total++;
      if ({hi, lo} !== {v[i].eh, v[i].el})
        $display("FAIL dir%0d_result got %h_%h want %h_%h", i, hi, lo, v[i].eh, v[i].el);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (done !== 1'b0) $display("FAIL dir%0d_done_fall got %b want 0", i, done); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int          nb;
    bit          held, ds;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'b0;
        1: a = 32'h8000_0000;
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = model(o, a, b);
      issue(o, a, b);
      wait_result(nb, held, ds);
      n_total++;
      if (nb != 33 || !held || ds !== 1'b1)
        $display("FAIL rnd%0d_timing got busy=%0d held=%b done=%b want 33/1/1", i, nb, held, ds);
      else n_pass++;
      n_total++;
      if ({hi, lo} !== exp)
        $display("FAIL rnd%0d_op%0d %h,%h got %h_%h want %h", i, o, a, b, hi, lo, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp1, exp2;
    int          nb;
    bit          held, ds, got;
    exp1 = model(2'b01, 32'hFFFF_FFFB, 32'h0000_0007);
    exp2 = model(2'b10, 32'd100, 32'd7);
    issue(2'b01, 32'hFFFF_FFFB, 32'h0000_0007);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    rs    = 32'hDEAD_BEEF;
    rt    = 32'h0000_0003;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    n_total++; if (!got) $display("FAIL b2b_first_done got none want pulse"); else n_pass++;
    n_total++;
    if ({hi, lo} !== exp1) $display("FAIL b2b_first_result got %h_%h want %h", hi, lo, exp1);
    else n_pass++;
    start = 1'b1;
    op    = 2'b10;
    rs    = 32'd100;
    rt    = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_no_bubble got busy=%b done=%b want 1/0", busy, done);
    else n_pass++;
    wait_result(nb, held, ds);
    n_total++;
    if (nb != 32 || ds !== 1'b1)
      $display("FAIL b2b_second_timing got busy=%0d done=%b want 32/1", nb, ds);
    else n_pass++;
    n_total++;
    if ({hi, lo} !== exp2) $display("FAIL b2b_second_result got %h_%h want %h", hi, lo, exp2);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    bit          stray;
    int          nb;
    bit          held, ds;
    logic [63:0] exp;
    issue(2'b11, 32'h7654_3210, 32'h0000_0013);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL areset_flags got busy=%b done=%b want 0/0", busy, done);
    else n_pass++;
    n_total++;
    if (hi !== 32'b0 || lo !== 32'b0) $display("FAIL areset_hilo got %h_%h want 0_0", hi, lo);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy || hi !== 32'b0 || lo !== 32'b0) stray = 1'b1;
    end
    n_total++;
    if (stray) $display("FAIL areset_quiet got activity want none"); else n_pass++;
    exp = model(2'b00, 32'd3, 32'd5);
    issue(2'b00, 32'd3, 32'd5);
    wait_result(nb, held, ds);
    n_total++;
    if ({hi, lo} !== exp || nb != 33 || ds !== 1'b1)
      $display("FAIL areset_recover got %h_%h busy=%0d want %h busy=33", hi, lo, nb, exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
